// File: rtl/pacman_map_pkg.sv
// Shared maze geometry, collision codes and the static tile lookup used by
// the Pacman collision logic.
package pacman_map_pkg;

  localparam int unsigned MAP_W   = 40;
  localparam int unsigned MAP_H   = 30;
  localparam int unsigned START_X = 20;
  localparam int unsigned START_Y = 20;

  localparam int unsigned MAP_TILES = MAP_W * MAP_H;
  localparam int unsigned IDX_W     = $clog2(MAP_TILES);

  localparam logic [3:0] COLL_NONE  = 4'b0000;
  localparam logic [3:0] COLL_WALL  = 4'b0001;
  localparam logic [3:0] COLL_PILL  = 4'b0010;
  localparam logic [3:0] COLL_POWER = 4'b0100;
  localparam logic [3:0] COLL_GHOST = 4'b1000;

  typedef enum logic [1:0] {
    EMPTY,
    WALL,
    PILL,
    POWER
  } tile_t;

  // Static contents of a tile, ignoring whether it has been eaten.
  function automatic tile_t static_tile(input logic [5:0] x, input logic [4:0] y);
    int unsigned xi;
    int unsigned yi;
    tile_t       t;
    xi = 32'(x);
    yi = 32'(y);
    if (xi >= MAP_W || yi >= MAP_H) begin
      t = WALL;
    end else if (xi == 0 || xi == MAP_W - 1 || yi == 0 || yi == MAP_H - 1) begin
      t = WALL;
    end else if (yi == 10 && xi >= 10 && xi <= 29) begin
      t = WALL;
    end else if (xi == 30 && yi >= 14 && yi <= 25) begin
      t = WALL;
    end else if ((xi == 1 || xi == MAP_W - 2) && (yi == 1 || yi == MAP_H - 2)) begin
      t = POWER;
    end else if (xi == START_X && yi == START_Y) begin
      t = EMPTY;
    end else if (x[0] == y[0]) begin
      t = PILL;
    end else begin
      t = EMPTY;
    end
    return t;
  endfunction

endpackage

// File: rtl/pacman_map_rom.sv
// Combinational map lookup: static tile class for a tile coordinate.
module pacman_map_rom
  import pacman_map_pkg::*;
(
  input  logic [5:0] x,
  input  logic [4:0] y,
  output tile_t      tile
);

  assign tile = static_tile(x, y);

endmodule

// File: rtl/collision_detect.sv
// Registered collision classification for Pacman's candidate tile, with an
// eaten-pill bitmap and a running count of eaten pills and power pellets.
module collision_detect
  import pacman_map_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [5:0]  next_pacman_x,
  input  logic [4:0]  next_pacman_y,
  output logic [3:0]  collision_type,
  output logic [32:0] pill_count
);

  tile_t                tile;
  logic                 is_food;
  logic                 already_eaten;
  logic                 eat;
  logic [IDX_W-1:0]     tile_idx;
  logic [3:0]           coll_next;
  logic [MAP_TILES-1:0] eaten;

  pacman_map_rom u_map_rom (
    .x    (next_pacman_x),
    .y    (next_pacman_y),
    .tile (tile)
  );

  // Food only exists in range, so the index is forced to 0 otherwise to keep it bounded.
  always_comb begin
    is_food  = (tile == PILL) || (tile == POWER);
    tile_idx = '0;
    if (is_food) begin
      tile_idx = IDX_W'(next_pacman_y) * IDX_W'(MAP_W) + IDX_W'(next_pacman_x);
    end
    already_eaten = eaten[tile_idx];
    eat           = is_food && !already_eaten;
  end

  always_comb begin
    coll_next = COLL_NONE;
    unique case (tile)
      WALL:    coll_next = COLL_WALL;
      PILL:    coll_next = already_eaten ? COLL_NONE : COLL_PILL;
      POWER:   coll_next = already_eaten ? COLL_NONE : COLL_POWER;
      default: coll_next = COLL_NONE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      collision_type <= COLL_NONE;
      pill_count     <= '0;
      eaten          <= '0;
    end else begin
      collision_type <= coll_next;
      if (eat) begin
        eaten[tile_idx] <= 1'b1;
        pill_count      <= pill_count + 33'd1;
      end
    end
  end

endmodule

// File: tb/tb_collision_detect.sv
// Self-checking bench for collision_detect: directed scenarios plus a map
// sweep and randomized walk against a behavioural maze model.
module tb_collision_detect;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic [5:0]  nx       = '0;
  logic [4:0]  ny       = '0;
  logic [3:0]  collision_type;
  logic [32:0] pill_count;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         eaten_m [0:39][0:29];
  logic [3:0] exp_type;
  longint     exp_count;

  always #5 CLOCK_50 = ~CLOCK_50;

  collision_detect dut (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .next_pacman_x  (nx),
    .next_pacman_y  (ny),
    .collision_type (collision_type),
    .pill_count     (pill_count)
  );

  // Static class code for a tile, straight from the maze description.
  function automatic logic [3:0] m_class(input int x, input int y);
    bit wall;
    wall = (x >= 40) || (y >= 30) || (x == 0) || (x == 39) || (y == 0) || (y == 29) ||
           (y == 10 && x >= 10 && x <= 29) || (x == 30 && y >= 14 && y <= 25);
    if (wall) return 4'b0001;
    if ((x == 1 || x == 38) && (y == 1 || y == 28)) return 4'b0100;
    if (x == 20 && y == 20) return 4'b0000;
    if ((x + y) % 2 == 0) return 4'b0010;
    return 4'b0000;
  endfunction

  // Present one coordinate for one clock edge and advance the model.
  task automatic drive(input int x, input int y, input bit rst);
    int         xi;
    int         yi;
    logic [3:0] c;
    xi    = x & 63;
    yi    = y & 31;
    reset = rst;
    nx    = 6'(xi);
    ny    = 5'(yi);
    @(posedge CLOCK_50);
    if (rst) begin
      exp_type  = 4'b0000;
      exp_count = 0;
      foreach (eaten_m[i, j]) eaten_m[i][j] = 1'b0;
    end else begin
      c = m_class(xi, yi);
      if (c == 4'b0010 || c == 4'b0100) begin
        if (eaten_m[xi][yi]) begin
          exp_type = 4'b0000;
        end else begin
          exp_type         = c;
          eaten_m[xi][yi]  = 1'b1;
          exp_count        = exp_count + 1;
        end
      end else begin
        exp_type = c;
      end
    end
    #1;
  endtask

  task automatic test_reset;
    drive(20, 20, 1'b1);
    checks++;
    if (collision_type !== 4'b0000 || pill_count !== 33'd0) begin
      errors++;
      $display("FAIL reset_state: type=%b count=%0d, want 0000/0", collision_type, pill_count);
    end
    drive(20, 20, 1'b0);
    checks++;
    if (collision_type !== 4'b0000 || pill_count !== 33'd0) begin
      errors++;
      $display("FAIL start_tile: type=%b count=%0d, want 0000/0", collision_type, pill_count);
    end
  endtask

  task automatic test_pill_hold;
    logic [3:0] want;
    for (int i = 0; i < 3; i++) begin
      drive(20, 18, 1'b0);
      want = (i == 0) ? 4'b0010 : 4'b0000;
      checks++;
      if (collision_type !== want || pill_count !== 33'd1) begin
        errors++;
        $display("FAIL pill_hold[%0d]: type=%b count=%0d, want %b/1", i, collision_type,
                 pill_count, want);
      end
    end
  endtask

  task automatic test_walls;
    int wx [5] = '{0, 20, 30, 63, 5};
    int wy [5] = '{5, 10, 14, 20, 31};
    for (int i = 0; i < 5; i++) begin
      drive(wx[i], wy[i], 1'b0);
      checks++;
      if (collision_type !== 4'b0001 || pill_count !== 33'd1) begin
        errors++;
        $display("FAIL wall(%0d,%0d): type=%b count=%0d, want 0001/1", wx[i], wy[i],
                 collision_type, pill_count);
      end
    end
  endtask

  task automatic test_empty_power;
    drive(20, 19, 1'b0);
    checks++;
    if (collision_type !== 4'b0000 || pill_count !== 33'd1) begin
      errors++;
      $display("FAIL empty(20,19): type=%b count=%0d, want 0000/1", collision_type, pill_count);
    end
    drive(31, 14, 1'b0);
    checks++;
    if (collision_type !== 4'b0000 || pill_count !== 33'd1) begin
      errors++;
      $display("FAIL empty(31,14): type=%b count=%0d, want 0000/1", collision_type, pill_count);
    end
    drive(1, 1, 1'b0);
    checks++;
    if (collision_type !== 4'b0100 || pill_count !== 33'd2) begin
      errors++;
      $display("FAIL power(1,1): type=%b count=%0d, want 0100/2", collision_type, pill_count);
    end
    drive(1, 1, 1'b0);
    checks++;
    if (collision_type !== 4'b0000 || pill_count !== 33'd2) begin
      errors++;
      $display("FAIL power_eaten: type=%b count=%0d, want 0000/2", collision_type, pill_count);
    end
  endtask

  task automatic test_revisit;
    drive(20, 18, 1'b0);
    checks++;
    if (collision_type !== 4'b0000 || pill_count !== 33'd2) begin
      errors++;
      $display("FAIL revisit: type=%b count=%0d, want 0000/2", collision_type, pill_count);
    end
  endtask

  task automatic test_reset_restore;
    drive(20, 18, 1'b1);
    drive(20, 18, 1'b0);
    checks++;
    if (collision_type !== 4'b0010 || pill_count !== 33'd1) begin
      errors++;
      $display("FAIL restore: type=%b count=%0d, want 0010/1", collision_type, pill_count);
    end
  endtask

  task automatic test_back_to_back;
    int pills_seen;
    pills_seen = 0;
    drive(20, 20, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(20, (i % 2 == 0) ? 18 : 19, 1'b0);
      if (collision_type == 4'b0010) pills_seen++;
    end
    checks++;
    if (pills_seen != 1 || pill_count !== 33'd1) begin
      errors++;
      $display("FAIL alternate: pill_cycles=%0d count=%0d, want 1/1", pills_seen, pill_count);
    end
  endtask

  // Visit every encodable coordinate once; first visit exposes the static map.
  task automatic test_sweep;
    drive(0, 0, 1'b1);
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 64; x++) begin
        drive(x, y, 1'b0);
        checks++;
        if (collision_type !== exp_type || pill_count !== 33'(exp_count)) begin
          errors++;
          $display("FAIL sweep(%0d,%0d): type=%b count=%0d, want %b/%0d", x, y,
                   collision_type, pill_count, exp_type, exp_count);
        end
      end
    end
  endtask

  task automatic test_random;
    int  x;
    int  y;
    bit  rst;
    drive(0, 0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        x = 16 + $urandom_range(0, 7);
        y = 15 + $urandom_range(0, 7);
      end else begin
        x = $urandom_range(0, 63);
        y = $urandom_range(0, 31);
      end
      rst = ($urandom_range(0, 199) == 0);
      drive(x, y, rst);
      checks++;
      if (collision_type !== exp_type || pill_count !== 33'(exp_count) ||
          $countones(collision_type) > 1) begin
        errors++;
        $display("FAIL random[%0d](%0d,%0d,rst=%0d): type=%b count=%0d, want %b/%0d", i, x, y,
                 rst, collision_type, pill_count, exp_type, exp_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pill_hold();
    test_walls();
    test_empty_power();
    test_revisit();
    test_reset_restore();
    test_back_to_back();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/collision_detect.md
Name: collision_detect

Overview:
- Classifies the maze tile at Pacman's candidate next position (next_pacman_x/next_pacman_y, produced by the Pacman location controller) as empty, wall, pill or power pellet.
- Tracks which pills have been eaten and counts them.
- The location controller presents a candidate coordinate, waits one cycle, then reads collision_type. A wall code blocks the move; any other code lets the move proceed.

Parameters:
- none. Map geometry and contents are fixed constants in the shared package.

Ports:
- CLOCK_50  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- next_pacman_x  in  6  candidate tile column, 0..63
- next_pacman_y  in  5  candidate tile row, 0..31
- collision_type  out  4  registered one-hot tile class: 0000 empty/eaten, 0001 wall, 0010 pill, 0100 power pellet, 1000 reserved (ghost, never driven)
- pill_count  out  33  unsigned count of pills and power pellets eaten since reset

Behaviour:
- Map is 40 columns (x 0..39) by 30 rows (y 0..29).
- Walls:
  - border tiles: x=0, x=39, y=0, y=29
  - horizontal bar: y=10, x 10..29
  - vertical bar: x=30, y 14..25
  - any coordinate with x>=40 or y>=30 is out of range and treated as wall, including wrap values such as x=63 from 0-1.
- Power pellets: (1,1), (38,1), (1,28), (38,28).
- Pills: every other non-wall tile with (x+y) even, except start tile (20,20), which is empty.
- All remaining tiles are empty.
- Eaten bitmap: 1200 bits, one per in-range tile.
- Latency: on each rising edge, coordinates are sampled. collision_type is updated from map plus the eaten bitmap as it stood before that edge, so the value is valid one cycle after the coordinates are presented.
- Eating: at the same edge, if the sampled tile is a pill or power pellet and its eaten bit is 0:
  - set its eaten bit
  - pill_count += 1
- Consequences of eating:
  - If the coordinates are held, collision_type shows 0010/0100 for exactly one cycle, then 0000.
  - Each pill is counted once only.
  - Revisiting an eaten tile always gives 0000.
- Walls and empty tiles never change pill_count.
- pill_count does not saturate; 33-bit wrap is unreachable, since at most ~560 pills exist.
- Reset (also mid-operation) takes priority over everything else in that cycle:
  - collision_type=0000
  - pill_count=0
  - all eaten bits cleared, restoring every pill
  - no eat occurs in the reset cycle
- collision_type is always exactly one-hot or 0000.

Decomposition:
- Package pacman_map_pkg holds:
  - MAP_W=40, MAP_H=30, START_X=20, START_Y=20
  - the collision code constants COLL_NONE/WALL/PILL/POWER/GHOST
  - tile enum {EMPTY, WALL, PILL, POWER}
  - a pure function giving the static tile for (x,y)
- Sub-module pacman_map_rom: combinational, maps (x,y) to the static tile type.
- collision_detect owns the eaten bitmap, the output registers and the counter.

Test Plan:
- Reset asserted 1 cycle, then inputs (20,20) -> collision_type 0000, pill_count 0.
- Drive (20,18) and hold 3 cycles:
  - cycle 1: 0010, pill_count 1
  - cycles 2 and 3: 0000, pill_count stays 1
- Walls (0,5), (20,10), (30,14), (63,20), (5,31) -> 0001 each; pill_count unchanged.
- Empty tiles (20,19) and (31,14) -> 0000; power pellet (1,1) -> 0100 then 0000; pill_count +1.
- Revisit (20,18) -> 0000, no increment.
- Assert reset, then drive (20,18) -> 0010 and pill_count 1 again.
- Alternate (20,18)/(20,19) every cycle for 6 cycles from reset -> pill_count ends at 1; 0010 appears only once.
